// File: rtl/uart_debug_bridge.sv
// uart_debug_bridge: host byte-stream debug command decoder driving a
// single-outstanding 32-bit OBI-style bus manager.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command byte (0x11 READ, 0x12 WRITE, 0x13 EXEC)
// HDR   | collecting 4 LE address bytes (+ count byte for READ/WRITE)
// ACK   | sending 0x06
// BREQ  | bus request held until grant
// BWAIT | waiting for the bus response
// TXD   | sending the 4 bytes of a read word, LSB first
// RXD   | collecting 4 LE bytes of a write word
// EOT   | sending 0x04, then back to IDLE
// NAK   | sending 0x15 (bus error or host timeout), then back to IDLE
module uart_debug_bridge #(
    parameter logic [31:0] BootAddrAddr  = 32'h0300_0000,
    parameter logic [31:0] FetchEnAddr   = 32'h0300_0004,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    output logic        busy_o
);

    typedef enum logic [3:0] {IDLE, HDR, ACK, BREQ, BWAIT, TXD, RXD, EOT, NAK} state_e;
    typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_EXEC} cmd_e;

    localparam logic [7:0]  ByteAck = 8'h06;
    localparam logic [7:0]  ByteEot = 8'h04;
    localparam logic [7:0]  ByteNak = 8'h15;
    localparam logic [31:0] TmoLoad = 32'(TimeoutCycles);

    state_e      state_q, state_d;
    cmd_e        cmd_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] tout_q;
    logic [2:0]  byte_cnt_q;
    logic [8:0]  words_q;
    logic        exec_phase_q;
    logic        rx_ready_q;
    logic        busy_q;

    logic        rx_fire;
    logic        tx_fire;
    logic        is_cmd_byte;
    logic        last_hdr_byte;
    logic        timeout_hit;
    logic        rx_state;
    logic [31:0] addr_word;

    assign rx_fire       = rx_valid_i & rx_ready_q;
    assign tx_valid_o    = (state_q == ACK) || (state_q == TXD) ||
                           (state_q == EOT) || (state_q == NAK);
    assign tx_fire       = tx_valid_o & tx_ready_i;
    assign is_cmd_byte   = (rx_data_i == 8'h11) || (rx_data_i == 8'h12) || (rx_data_i == 8'h13);
    assign last_hdr_byte = (cmd_q == CMD_EXEC) ? (byte_cnt_q == 3'd3) : (byte_cnt_q == 3'd4);
    assign rx_state      = (state_q == HDR) || (state_q == RXD);
    // The down-counter reaching 1 on a cycle with no accepted byte means the
    // full idle window has elapsed; a zero load disables the check.
    assign timeout_hit   = (TimeoutCycles != 0) && rx_state && !rx_fire && (tout_q == 32'd1);
    assign addr_word     = {addr_q[31:2], 2'b00};

    assign rx_ready_o  = rx_ready_q;
    assign busy_o      = busy_q;
    assign obi_req_o   = (state_q == BREQ);
    assign obi_we_o    = (cmd_q != CMD_READ);
    assign obi_be_o    = 4'hF;
    // EXEC reuses the bus path: first write the boot address, then set fetch-enable.
    assign obi_addr_o  = (cmd_q == CMD_EXEC) ? (exec_phase_q ? {FetchEnAddr[31:2], 2'b00}
                                                             : {BootAddrAddr[31:2], 2'b00})
                                             : addr_word;
    assign obi_wdata_o = (cmd_q == CMD_EXEC) ? (exec_phase_q ? 32'd1 : addr_word) : data_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rx_fire && is_cmd_byte) state_d = HDR;
            HDR: begin
                if (timeout_hit)                  state_d = NAK;
                else if (rx_fire && last_hdr_byte) state_d = ACK;
            end
            ACK: if (tx_fire) state_d = (cmd_q == CMD_WRITE) ? RXD : BREQ;
            RXD: begin
                if (timeout_hit)                          state_d = NAK;
                else if (rx_fire && byte_cnt_q == 3'd3)   state_d = BREQ;
            end
            BREQ: if (obi_gnt_i) state_d = BWAIT;
            BWAIT: begin
                if (obi_rvalid_i) begin
                    if (obi_err_i) begin
                        state_d = NAK;
                    end else begin
                        case (cmd_q)
                            CMD_READ:  state_d = TXD;
                            CMD_WRITE: state_d = (words_q == 9'd1) ? EOT : RXD;
                            default:   state_d = exec_phase_q ? EOT : BREQ;
                        endcase
                    end
                end
            end
            TXD: if (tx_fire && byte_cnt_q == 3'd3) state_d = (words_q != 9'd0) ? BREQ : EOT;
            EOT, NAK: if (tx_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response byte selection
    always_comb begin
        tx_data_o = 8'h00;
        case (state_q)
            ACK:     tx_data_o = ByteAck;
            EOT:     tx_data_o = ByteEot;
            NAK:     tx_data_o = ByteNak;
            TXD:     tx_data_o = data_q[7:0];
            default: tx_data_o = 8'h00;
        endcase
    end

    // Command, address, word count and data shift register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q        <= CMD_READ;
            addr_q       <= 32'h0;
            data_q       <= 32'h0;
            byte_cnt_q   <= 3'd0;
            words_q      <= 9'd0;
            exec_phase_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_fire && is_cmd_byte) begin
                        case (rx_data_i)
                            8'h11:   cmd_q <= CMD_READ;
                            8'h12:   cmd_q <= CMD_WRITE;
                            default: cmd_q <= CMD_EXEC;
                        endcase
                        byte_cnt_q   <= 3'd0;
                        exec_phase_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (rx_fire) begin
                        if (byte_cnt_q < 3'd4) addr_q <= {rx_data_i, addr_q[31:8]};
                        else words_q <= (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                    end
                end
                ACK: if (tx_fire) byte_cnt_q <= 3'd0;
                RXD: begin
                    if (rx_fire) begin
                        data_q     <= {rx_data_i, data_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                    end
                end
                BWAIT: begin
                    if (obi_rvalid_i && !obi_err_i) begin
                        byte_cnt_q <= 3'd0;
                        if (cmd_q == CMD_EXEC) begin
                            exec_phase_q <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + 32'd4;
                            words_q <= words_q - 9'd1;
                        end
                        if (cmd_q == CMD_READ) data_q <= obi_rdata_i;
                    end
                end
                TXD: begin
                    if (tx_fire) begin
                        data_q     <= {8'h00, data_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Inter-byte timeout: reload on every accepted byte and outside HDR/RXD
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tout_q <= 32'h0;
        end else if (!rx_state || rx_fire) begin
            tout_q <= TmoLoad;
        end else if (tout_q != 32'h0) begin
            tout_q <= tout_q - 32'd1;
        end
    end

    // Registered rx_ready and busy follow the next state so they track state_q
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_ready_q <= (state_d == IDLE) || (state_d == HDR) || (state_d == RXD);
            busy_q     <= (state_d != IDLE);
        end
    end

endmodule
